// File: rtl/booth_product_accumulator_if.sv
// rtl/booth_product_accumulator_if.sv - product-in / sum-out handshake bundle
// Purpose: groups the input product stream, the result stream and the
//   synchronous clear of booth_product_accumulator.
// Ports (signals):
//   clear        abort the current block and any held result
//   in_valid     in_product is valid
//   in_ready     accumulator can take a product this cycle
//   in_product   signed product, PROD_W bits
//   out_valid    out_sum / out_overflow are valid
//   out_ready    downstream accepts the result
//   out_sum      signed accumulated sum, ACC_W bits
//   out_overflow signed overflow seen in any add of the block
// Modports: master = product source / result sink, slave = accumulator.
interface booth_product_accumulator_if #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 16
);
  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_product;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              out_overflow;

  modport master (
    output clear, in_valid, in_product, out_ready,
    input  in_ready, out_valid, out_sum, out_overflow
  );

  modport slave (
    input  clear, in_valid, in_product, out_ready,
    output in_ready, out_valid, out_sum, out_overflow
  );
endinterface

// File: rtl/booth_product_accumulator.sv
// rtl/booth_product_accumulator.sv - accumulates COUNT signed products per result
// Purpose: registered, flow-controlled stage behind the Booth multiplier.
//   Sums COUNT sign-extended products into an ACC_W accumulator and holds
//   the sum plus a sticky overflow flag on a valid/ready output.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  booth_product_accumulator_if.slave (clear, in_* stream, out_* stream)
// Configuration: BPA_SATURATE_EN defined -> each add clamps on overflow;
//   undefined -> adds wrap modulo 2^ACC_W.
module booth_product_accumulator #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 16,
  parameter int COUNT  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  booth_product_accumulator_if.slave    bus
);
  localparam int CNT_W = $clog2(COUNT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);
  localparam int MSB = ACC_W - 1;

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t                  state, state_d;
  logic signed [ACC_W-1:0] acc, acc_d, sum_q, sum_d;
  logic [CNT_W-1:0]        cnt, cnt_d;
  logic                    ovf, ovf_d, sovf_q, sovf_d;

  logic signed [ACC_W-1:0] prod_ext, base, raw, addv;
  logic [CNT_W-1:0]        base_cnt;
  logic                    base_ovf, add_ovf, beat;

  assign prod_ext = {{(ACC_W-PROD_W){bus.in_product[PROD_W-1]}}, bus.in_product};

  // In HOLD the only beat that can be accepted starts a fresh block, so the
  // adder operands come from zero instead of the (already cleared) acc.
  assign base     = (state == HOLD) ? '0 : acc;
  assign base_cnt = (state == HOLD) ? '0 : cnt;
  assign base_ovf = (state == HOLD) ? 1'b0 : ovf;

  assign raw     = base + prod_ext;
  assign add_ovf = (base[MSB] == prod_ext[MSB]) && (raw[MSB] != base[MSB]);

`ifdef BPA_SATURATE_EN
  localparam logic signed [ACC_W-1:0] MAX_V = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {1'b1, {(ACC_W-1){1'b0}}};
  // Overflow direction follows the common sign of the two addends.
  assign addv = add_ovf ? (base[MSB] ? MIN_V : MAX_V) : raw;
`else
  assign addv = raw;
`endif

  assign bus.in_ready     = (state == ACCUM) | bus.out_ready;
  assign beat             = bus.in_valid & bus.in_ready;
  assign bus.out_valid    = (state == HOLD);
  assign bus.out_sum      = sum_q;
  assign bus.out_overflow = sovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ACCUM;
      acc    <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
      sum_q  <= '0;
      sovf_q <= 1'b0;
    end else begin
      state  <= state_d;
      acc    <= acc_d;
      cnt    <= cnt_d;
      ovf    <= ovf_d;
      sum_q  <= sum_d;
      sovf_q <= sovf_d;
    end
  end

  always_comb begin
    state_d = state;
    acc_d   = acc;
    cnt_d   = cnt;
    ovf_d   = ovf;
    sum_d   = sum_q;
    sovf_d  = sovf_q;
    if (bus.clear) begin
      // clear wins over any handshake in the same cycle
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else if (beat) begin
      if (base_cnt == LAST) begin
        sum_d   = addv;
        sovf_d  = base_ovf | add_ovf;
        state_d = HOLD;
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
      end else begin
        state_d = ACCUM;
        acc_d   = addv;
        cnt_d   = base_cnt + CNT_W'(1);
        ovf_d   = base_ovf | add_ovf;
      end
    end else if ((state == HOLD) && bus.out_ready) begin
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end
  end
endmodule

// File: tb/tb_booth_product_accumulator.sv
// tb/tb_booth_product_accumulator.sv - randomized and directed check of booth_product_accumulator
module tb_booth_product_accumulator;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_product = 8'h00;
  logic       out_ready = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // d0: ACC_W=16 COUNT=4, d1: ACC_W=9 COUNT=4, d2: ACC_W=16 COUNT=1
  booth_product_accumulator_if #(.PROD_W(8), .ACC_W(16)) if0 ();
  booth_product_accumulator_if #(.PROD_W(8), .ACC_W(9))  if1 ();
  booth_product_accumulator_if #(.PROD_W(8), .ACC_W(16)) if2 ();

  assign if0.clear = clear; assign if0.in_valid = in_valid;
  assign if0.in_product = in_product; assign if0.out_ready = out_ready;
  assign if1.clear = clear; assign if1.in_valid = in_valid;
  assign if1.in_product = in_product; assign if1.out_ready = out_ready;
  assign if2.clear = clear; assign if2.in_valid = in_valid;
  assign if2.in_product = in_product; assign if2.out_ready = out_ready;

  booth_product_accumulator #(.PROD_W(8), .ACC_W(16), .COUNT(4)) d0 (.clk(clk), .rst(rst), .bus(if0));
  booth_product_accumulator #(.PROD_W(8), .ACC_W(9),  .COUNT(4)) d1 (.clk(clk), .rst(rst), .bus(if1));
  booth_product_accumulator #(.PROD_W(8), .ACC_W(16), .COUNT(1)) d2 (.clk(clk), .rst(rst), .bus(if2));

  logic a_rdy[3], a_val[3], a_ovf[3];
  int   a_sum[3];
  assign a_rdy[0] = if0.in_ready;  assign a_rdy[1] = if1.in_ready;  assign a_rdy[2] = if2.in_ready;
  assign a_val[0] = if0.out_valid; assign a_val[1] = if1.out_valid; assign a_val[2] = if2.out_valid;
  assign a_ovf[0] = if0.out_overflow; assign a_ovf[1] = if1.out_overflow; assign a_ovf[2] = if2.out_overflow;
  assign a_sum[0] = $signed(if0.out_sum);
  assign a_sum[1] = $signed(if1.out_sum);
  assign a_sum[2] = $signed(if2.out_sum);

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Behavioural model: per DUT, the running block value as a plain integer.
  int accw[3] = '{16, 9, 16};
  int cntp[3] = '{4, 4, 1};
  int m_acc[3], m_n[3], m_sum[3];
  bit m_ovf[3], m_sovf[3], m_hold[3];

  function automatic int add_m(input int a, input int p, input int w, output bit o);
    int full, mx, mn;
    full = a + p;
    mx = (1 << (w - 1)) - 1;
    mn = -(1 << (w - 1));
    o = (full > mx) || (full < mn);
`ifdef BPA_SATURATE_EN
    if (full > mx) return mx;
    if (full < mn) return mn;
`else
    if (full > mx) return full - (1 << w);
    if (full < mn) return full + (1 << w);
`endif
    return full;
  endfunction

  always @(posedge clk or posedge rst) begin
    bit o, rdy;
    int p;
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_acc[k] = 0; m_n[k] = 0; m_sum[k] = 0;
        m_ovf[k] = 0; m_sovf[k] = 0; m_hold[k] = 0;
      end else begin
        rdy = !m_hold[k] || out_ready;
        p = $signed(in_product);
        if (clear) begin
          m_hold[k] = 0; m_acc[k] = 0; m_n[k] = 0; m_ovf[k] = 0;
        end else begin
          if (m_hold[k] && out_ready) begin
            m_hold[k] = 0; m_acc[k] = 0; m_n[k] = 0; m_ovf[k] = 0;
          end
          if (in_valid && rdy) begin
            m_acc[k] = add_m(m_acc[k], p, accw[k], o);
            m_ovf[k] = m_ovf[k] | o;
            m_n[k]++;
            if (m_n[k] == cntp[k]) begin
              m_sum[k] = m_acc[k]; m_sovf[k] = m_ovf[k]; m_hold[k] = 1;
              m_acc[k] = 0; m_n[k] = 0; m_ovf[k] = 0;
            end
          end
        end
      end
    end
  end

  // Compare process: every falling edge, all three DUTs against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("d%0d out_valid", k), int'(a_val[k]), int'(m_hold[k]));
      chk($sformatf("d%0d in_ready", k), int'(a_rdy[k]), int'(!m_hold[k] || out_ready));
      if (m_hold[k]) begin
        chk($sformatf("d%0d out_sum", k), a_sum[k], m_sum[k]);
        chk($sformatf("d%0d out_overflow", k), int'(a_ovf[k]), int'(m_sovf[k]));
      end
    end
  end

  task automatic step(input logic v, input logic [7:0] p, input logic ordy, input logic clr);
    in_valid = v; in_product = p; out_ready = ordy; clear = clr;
    @(posedge clk); #1;
  endtask

  logic [7:0] t1 [4] = '{8'h0C, 8'hFA, 8'h31, 8'hC0};
  int nres;

  initial begin
    #1;
    chk("reset out_valid", int'(if0.out_valid), 0);
    chk("reset out_sum", int'(if0.out_sum), 0);
    chk("reset out_overflow", int'(if0.out_overflow), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: basic block of four
    for (int i = 0; i < 4; i++) begin
      if (i == 3) chk("t1 no early valid", int'(if0.out_valid), 0);
      step(1'b1, t1[i], 1'b1, 1'b0);
    end
    chk("t1 out_valid", int'(if0.out_valid), 1);
    chk("t1 out_sum", int'(if0.out_sum), 16'hFFF7);
    chk("t1 out_overflow", int'(if0.out_overflow), 0);
    chk("t4 count1 echo", int'(if2.out_sum), 16'hFFC0);

    // 3: backpressure
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 8'h00, 1'b0, 1'b0);
      chk("t3 held sum", int'(if0.out_sum), 16'hFFF7);
      chk("t3 in_ready low", int'(if0.in_ready), 0);
    end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t3 single handshake", int'(if0.out_valid), 0);

    // 2: overflow in the 9-bit accumulator
    for (int i = 0; i < 4; i++) step(1'b1, 8'h7F, 1'b1, 1'b0);
`ifdef BPA_SATURATE_EN
    chk("t2 sat sum", int'(if1.out_sum), 9'h0FF);
`else
    chk("t2 wrap sum", int'(if1.out_sum), 9'h1FC);
`endif
    chk("t2 ovf", int'(if1.out_overflow), 1);
    chk("t2 wide sum", int'(if0.out_sum), 16'h01FC);
    chk("t2 wide ovf", int'(if0.out_overflow), 0);

    // 4: back-to-back, no stall
    nres = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_product = 8'h02; out_ready = 1'b1; clear = 1'b0;
      #1;
      chk("t4 in_ready", int'(if0.in_ready), 1);
      @(posedge clk); #1;
      chk("t4 count1 sum", int'(if2.out_sum), 2);
      if (if0.out_valid) begin
        nres++;
        chk("t4 sum", int'(if0.out_sum), 16'h0008);
      end
    end
    chk("t4 results", nres, 2);

    // 5: clear mid-block, with a beat presented
    step(1'b1, 8'h01, 1'b1, 1'b0);
    step(1'b1, 8'h01, 1'b1, 1'b0);
    step(1'b1, 8'h01, 1'b1, 1'b1);
    chk("t5 no output", int'(if0.out_valid), 0);
    for (int i = 0; i < 4; i++) step(1'b1, 8'h01, 1'b1, 1'b0);
    chk("t5 sum", int'(if0.out_sum), 16'h0004);
    chk("t5 ovf", int'(if0.out_overflow), 0);

    // 6: async reset mid-block and in HOLD
    step(1'b1, 8'h05, 1'b1, 1'b0);
    step(1'b1, 8'h05, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 chk("t6 mid rst sum", int'(if0.out_sum), 0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, 8'h09, 1'b0, 1'b0);
    chk("t6 in hold", int'(if0.out_valid), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6 rst valid", int'(if0.out_valid), 0);
    chk("t6 rst sum", int'(if0.out_sum), 0);
    chk("t6 rst ovf", int'(if0.out_overflow), 0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, 8'h03, 1'b1, 1'b0);
    chk("t6 fresh sum", int'(if0.out_sum), 16'h000C);

    // random traffic against the model
    for (int i = 0; i < 3000; i++)
      step(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0, ($urandom % 50) == 0);
    step(1'b0, 8'h00, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
